// File: rtl/dmem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_if
//
// Bundles the signals between the load/store controller, the datapath that
// issues requests and the data memory it reads and writes.
//
//   Request channel (datapath -> controller)
//     req_valid   request present
//     req_ready   controller can accept a request
//     req_op      operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU,
//                 101 SW, 110 SH, 111 SB
//     req_addr    byte address
//     req_wdata   store data (SH uses [15:0], SB uses [7:0])
//
//   Response channel (controller -> datapath)
//     resp_valid  one-cycle response pulse, no backpressure
//     resp_rdata  load result, 0 for stores and errors
//     resp_err    misaligned or out-of-range access
//
//   Memory channel (controller -> data memory)
//     mem_read    read strobe
//     mem_write   write strobe, one cycle per write
//     mem_addr    word index
//     mem_wdata   full word to write
//     mem_rdata   word returned by the memory
//
// The controller connects through the slave modport; the surrounding
// environment (datapath plus memory) connects through the master modport.
// ---------------------------------------------------------------------------
interface dmem_access_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_op,
        input  req_addr,
        input  req_wdata,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid,
        input  req_ready,
        output req_op,
        output req_addr,
        output req_wdata,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//
// Initiator side of the word-organised data memory. Accepts one load or
// store per handshake, drives the memory read/write strobes, word address
// and write data, extracts and extends bytes/halfwords for sub-word loads
// and performs read-modify-write for sub-word stores. Exactly one response
// is returned per accepted request; misaligned or out-of-range accesses are
// flagged without any memory strobe.
//
// Parameters
//   DEPTH     number of 32-bit words in the data memory
//   READ_LAT  cycles mem_read is held before read data is sampled (1..4)
//
// Ports
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   request/response/memory signals (dmem_access_ctrl_if.slave)
//
// Sequence: IDLE -> (RD ->) (WR ->) RESP -> IDLE. Errors go straight from
// IDLE to RESP. SW skips RD; loads skip WR; SH/SB use both.
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    dmem_access_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    // Read counter runs 0..READ_LAT-1; two bits cover the legal 1..4 range.
    localparam logic [1:0]  RD_LAST = 2'(READ_LAT - 1);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic [1:0]  state;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [1:0]  rd_cnt;

    logic        req_misaligned;
    logic        req_err;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        op_is_store;

    // Error decode on the incoming request, evaluated at acceptance.
    always_comb begin
        req_misaligned = 1'b0;
        case (bus.req_op)
            OP_LW, OP_SW:         req_misaligned = |bus.req_addr[1:0];
            OP_LH, OP_LHU, OP_SH: req_misaligned = bus.req_addr[0];
            default:              req_misaligned = 1'b0;
        endcase
        req_err = req_misaligned | (bus.req_addr[31:2] >= DEPTH_W);
    end

    // Lane selection from the word being read, using the registered address.
    // Little-endian: byte lane k is bits [8k+7:8k].
    always_comb begin
        byte_lane = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_lane = bus.mem_rdata[7:0];
            2'd1:    byte_lane = bus.mem_rdata[15:8];
            2'd2:    byte_lane = bus.mem_rdata[23:16];
            default: byte_lane = bus.mem_rdata[31:24];
        endcase
        half_lane = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    end

    // Load result with sign or zero extension.
    always_comb begin
        load_data = 32'h0;
        case (op_q)
            OP_LW:   load_data = bus.mem_rdata;
            OP_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_data = {16'h0, half_lane};
            OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_data = {24'h0, byte_lane};
            default: load_data = 32'h0;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lane of the word
    // just read, keeping the other lanes as the memory returned them.
    always_comb begin
        merged_word = bus.mem_rdata;
        if (op_q == OP_SH) begin
            if (addr_q[1])
                merged_word = {wdata_q[15:0], bus.mem_rdata[15:0]};
            else
                merged_word = {bus.mem_rdata[31:16], wdata_q[15:0]};
        end else if (op_q == OP_SB) begin
            case (addr_q[1:0])
                2'd0:    merged_word = {bus.mem_rdata[31:8], wdata_q[7:0]};
                2'd1:    merged_word = {bus.mem_rdata[31:16], wdata_q[7:0], bus.mem_rdata[7:0]};
                2'd2:    merged_word = {bus.mem_rdata[31:24], wdata_q[7:0], bus.mem_rdata[15:0]};
                default: merged_word = {wdata_q[7:0], bus.mem_rdata[23:0]};
            endcase
        end
    end

    assign op_is_store = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);

    // Control sequence. All outputs are decoded from state, so an
    // asynchronous reset drops strobes and responses immediately and an
    // aborted request never produces a write or a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            rd_cnt  <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        rdata_q <= 32'h0;
                        err_q   <= req_err;
                        rd_cnt  <= 2'd0;
                        if (req_err)
                            state <= ST_RESP;
                        else if (bus.req_op == OP_SW)
                            state <= ST_WR;
                        else
                            state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (rd_cnt == RD_LAST) begin
                        if (op_is_store) begin
                            wdata_q <= merged_word;
                            state   <= ST_WR;
                        end else begin
                            rdata_q <= load_data;
                            state   <= ST_RESP;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                ST_WR:   state <= ST_RESP;
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = (state == ST_RESP) ? rdata_q : 32'h0;
    assign bus.resp_err   = (state == ST_RESP) & err_q;
    assign bus.mem_read   = (state == ST_RD);
    assign bus.mem_write  = (state == ST_WR);
    assign bus.mem_addr   = ((state == ST_RD) || (state == ST_WR)) ? {2'b00, addr_q[31:2]} : 32'h0;
    assign bus.mem_wdata  = (state == ST_WR) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Directed bench for dmem_access_ctrl. Two instances share clk/rst: dut0
// with READ_LAT = 1 and dut1 with READ_LAT = 3, each attached to its own
// 256-word behavioural memory. Each scenario task drives its stimulus and
// compares against hand-computed values; the summary line reports totals.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl_if bus0 ();
    dmem_access_ctrl_if bus1 ();

    dmem_access_ctrl #(.DEPTH(256), .READ_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_access_ctrl #(.DEPTH(256), .READ_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Behavioural memories with a preload port for the bench.
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic        pre_we0 = 1'b0;
    logic        pre_we1 = 1'b0;
    logic [7:0]  pre_addr = 8'h0;
    logic [31:0] pre_data = 32'h0;

    always @(posedge clk) begin
        if (pre_we0)
            mem0[pre_addr] <= pre_data;
        else if (bus0.mem_write)
            mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
    end

    always @(posedge clk) begin
        if (pre_we1)
            mem1[pre_addr] <= pre_data;
        else if (bus1.mem_write)
            mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    end

    assign bus0.mem_rdata = bus0.mem_read ? mem0[bus0.mem_addr[7:0]] : 32'h0;
    assign bus1.mem_rdata = bus1.mem_read ? mem1[bus1.mem_addr[7:0]] : 32'h0;

    // Event counters for dut0, sampled mid-cycle.
    int resp0_cnt = 0;
    int wr0_cnt   = 0;
    always @(negedge clk) begin
        if (bus0.resp_valid) resp0_cnt <= resp0_cnt + 1;
        if (bus0.mem_write)  wr0_cnt   <= wr0_cnt + 1;
    end

    // Called at a negedge; returns at the next negedge.
    task automatic preload(input bit which, input logic [7:0] idx, input logic [31:0] d);
        pre_addr = idx;
        pre_data = d;
        if (which) pre_we1 = 1'b1;
        else       pre_we0 = 1'b1;
        @(posedge clk);
        #1;
        pre_we0 = 1'b0;
        pre_we1 = 1'b0;
        @(negedge clk);
    endtask

    // Presents one request to dut0 at a negedge, lets it be accepted at the
    // next rising edge (cycle 0) and returns at the negedge of cycle 1.
    task automatic issue0(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        bus0.req_op    = op;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        bus0.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        bus0.req_op    = 3'b000;
        bus0.req_addr  = 32'h0;
        bus0.req_wdata = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready got %b expected 1", bus0.req_ready);
        end
        checks++;
        if ({bus0.resp_valid, bus0.resp_err, bus0.mem_read, bus0.mem_write} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_strobes got %b expected 0000",
                               {bus0.resp_valid, bus0.resp_err, bus0.mem_read, bus0.mem_write});
        end
        checks++;
        if ({bus0.resp_rdata, bus0.mem_addr, bus0.mem_wdata} !== 96'h0) begin
            errors++; $display("[TB] FAIL reset_data got %h %h %h expected 0 0 0",
                               bus0.resp_rdata, bus0.mem_addr, bus0.mem_wdata);
        end
        checks++;
        if (bus1.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready_lat3 got %b expected 1", bus1.req_ready);
        end
    endtask

    task automatic test_lw();
        preload(1'b0, 8'd5, 32'h87654321);
        issue0(OP_LW, 32'h14, 32'h0);
        checks++;
        if (bus0.mem_read !== 1'b1 || bus0.mem_addr !== 32'd5 || bus0.resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL lw_cycle1 got read=%b addr=%h resp=%b expected read=1 addr=5 resp=0",
                               bus0.mem_read, bus0.mem_addr, bus0.resp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 32'h87654321 || bus0.resp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL lw_resp got valid=%b rdata=%h err=%b expected 1 87654321 0",
                               bus0.resp_valid, bus0.resp_rdata, bus0.resp_err);
        end
        checks++;
        if (bus0.req_ready !== 1'b0 || bus0.mem_read !== 1'b0) begin
            errors++; $display("[TB] FAIL lw_resp_ready got ready=%b read=%b expected 0 0",
                               bus0.req_ready, bus0.mem_read);
        end
        @(negedge clk);
        checks++;
        if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL lw_idle got ready=%b resp=%b expected 1 0",
                               bus0.req_ready, bus0.resp_valid);
        end
    endtask

    task automatic test_subword_loads();
        logic [2:0]  op_t  [4];
        logic [31:0] adr_t [4];
        logic [31:0] exp_t [4];
        op_t[0] = OP_LB;  adr_t[0] = 32'h17; exp_t[0] = 32'hFFFFFF87;
        op_t[1] = OP_LBU; adr_t[1] = 32'h17; exp_t[1] = 32'h00000087;
        op_t[2] = OP_LH;  adr_t[2] = 32'h16; exp_t[2] = 32'hFFFF8765;
        op_t[3] = OP_LHU; adr_t[3] = 32'h14; exp_t[3] = 32'h00004321;
        for (int i = 0; i < 4; i++) begin
            issue0(op_t[i], adr_t[i], 32'h0);
            @(negedge clk);
            checks++;
            if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== exp_t[i] || bus0.resp_err !== 1'b0) begin
                errors++; $display("[TB] FAIL subword_load_%0d got valid=%b rdata=%h err=%b expected 1 %h 0",
                                   i, bus0.resp_valid, bus0.resp_rdata, bus0.resp_err, exp_t[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sb();
        issue0(OP_SB, 32'h15, 32'h000000AA);
        checks++;
        if (bus0.mem_read !== 1'b1 || bus0.mem_addr !== 32'd5 || bus0.mem_write !== 1'b0) begin
            errors++; $display("[TB] FAIL sb_cycle1 got read=%b addr=%h write=%b expected 1 5 0",
                               bus0.mem_read, bus0.mem_addr, bus0.mem_write);
        end
        @(negedge clk);
        checks++;
        if (bus0.mem_write !== 1'b1 || bus0.mem_read !== 1'b0 ||
            bus0.mem_addr !== 32'd5 || bus0.mem_wdata !== 32'h8765AA21) begin
            errors++; $display("[TB] FAIL sb_cycle2 got write=%b read=%b addr=%h wdata=%h expected 1 0 5 8765aa21",
                               bus0.mem_write, bus0.mem_read, bus0.mem_addr, bus0.mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 32'h0 || bus0.resp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL sb_resp got valid=%b rdata=%h err=%b expected 1 0 0",
                               bus0.resp_valid, bus0.resp_rdata, bus0.resp_err);
        end
        checks++;
        if (mem0[5] !== 32'h8765AA21) begin
            errors++; $display("[TB] FAIL sb_memword got %h expected 8765aa21", mem0[5]);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [2:0]  op_t  [3];
        logic [31:0] adr_t [3];
        int          w0;
        op_t[0] = OP_LW; adr_t[0] = 32'h16;
        op_t[1] = OP_SH; adr_t[1] = 32'h15;
        op_t[2] = OP_SW; adr_t[2] = 32'h400;
        w0 = wr0_cnt;
        for (int i = 0; i < 3; i++) begin
            issue0(op_t[i], adr_t[i], 32'hDEADBEEF);
            checks++;
            if (bus0.resp_valid !== 1'b1 || bus0.resp_err !== 1'b1 || bus0.resp_rdata !== 32'h0 ||
                bus0.mem_read !== 1'b0 || bus0.mem_write !== 1'b0) begin
                errors++; $display("[TB] FAIL error_resp_%0d got valid=%b err=%b rdata=%h read=%b write=%b expected 1 1 0 0 0",
                                   i, bus0.resp_valid, bus0.resp_err, bus0.resp_rdata,
                                   bus0.mem_read, bus0.mem_write);
            end
            @(negedge clk);
            checks++;
            if (bus0.resp_valid !== 1'b0 || bus0.mem_read !== 1'b0 ||
                bus0.mem_write !== 1'b0 || bus0.req_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL error_after_%0d got valid=%b read=%b write=%b ready=%b expected 0 0 0 1",
                                   i, bus0.resp_valid, bus0.mem_read, bus0.mem_write, bus0.req_ready);
            end
        end
        checks++;
        if (wr0_cnt != w0) begin
            errors++; $display("[TB] FAIL error_no_write got %0d writes expected 0", wr0_cnt - w0);
        end
    endtask

    task automatic test_reset_abort();
        int r0;
        int w0;
        preload(1'b0, 8'd5, 32'h87654321);
        r0 = resp0_cnt;
        w0 = wr0_cnt;
        issue0(OP_SH, 32'h14, 32'h0000BEEF);
        checks++;
        if (bus0.mem_read !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_rd got read=%b expected 1", bus0.mem_read);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus0.mem_read !== 1'b0 || bus0.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_async got read=%b ready=%b expected 0 1",
                               bus0.mem_read, bus0.req_ready);
        end
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (resp0_cnt != r0 || wr0_cnt != w0) begin
            errors++; $display("[TB] FAIL abort_quiet got resp=%0d writes=%0d expected 0 0",
                               resp0_cnt - r0, wr0_cnt - w0);
        end
        checks++;
        if (mem0[5] !== 32'h87654321 || bus0.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_mem got word=%h ready=%b expected 87654321 1",
                               mem0[5], bus0.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = resp0_cnt;
        bus0.req_op    = OP_SW;
        bus0.req_addr  = 32'h8;
        bus0.req_wdata = 32'h12345678;
        bus0.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus0.req_op    = OP_LW;
        bus0.req_wdata = 32'h0;
        @(negedge clk);
        checks++;
        if (bus0.mem_write !== 1'b1 || bus0.mem_addr !== 32'd2 ||
            bus0.mem_wdata !== 32'h12345678 || bus0.req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_sw_write got write=%b addr=%h wdata=%h ready=%b expected 1 2 12345678 0",
                               bus0.mem_write, bus0.mem_addr, bus0.mem_wdata, bus0.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 32'h0 || bus0.req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_sw_resp got valid=%b rdata=%h ready=%b expected 1 0 0",
                               bus0.resp_valid, bus0.resp_rdata, bus0.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus0.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_ready_cycle3 got %b expected 1", bus0.req_ready);
        end
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        bus0.req_addr  = 32'h0;
        bus0.req_op    = 3'b000;
        @(negedge clk);
        checks++;
        if (bus0.mem_read !== 1'b1 || bus0.mem_addr !== 32'd2) begin
            errors++; $display("[TB] FAIL b2b_lw_read got read=%b addr=%h expected 1 2",
                               bus0.mem_read, bus0.mem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== 32'h12345678 || bus0.resp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_lw_resp got valid=%b rdata=%h err=%b expected 1 12345678 0",
                               bus0.resp_valid, bus0.resp_rdata, bus0.resp_err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (resp0_cnt - r0 != 2) begin
            errors++; $display("[TB] FAIL b2b_resp_count got %0d expected 2", resp0_cnt - r0);
        end
    endtask

    task automatic test_read_latency();
        preload(1'b1, 8'd5, 32'h87654321);
        bus1.req_op    = OP_LW;
        bus1.req_addr  = 32'h14;
        bus1.req_wdata = 32'h0;
        bus1.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus1.mem_read !== 1'b1 || bus1.mem_addr !== 32'd5 || bus1.resp_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL lat3_cycle%0d got read=%b addr=%h resp=%b expected 1 5 0",
                                   c, bus1.mem_read, bus1.mem_addr, bus1.resp_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (bus1.resp_valid !== 1'b1 || bus1.resp_rdata !== 32'h87654321 ||
            bus1.resp_err !== 1'b0 || bus1.mem_read !== 1'b0) begin
            errors++; $display("[TB] FAIL lat3_resp got valid=%b rdata=%h err=%b read=%b expected 1 87654321 0 0",
                               bus1.resp_valid, bus1.resp_rdata, bus1.resp_err, bus1.mem_read);
        end
        @(negedge clk);
    endtask

    initial begin
        bus0.req_valid = 1'b0; bus0.req_op = 3'b000; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
        bus1.req_valid = 1'b0; bus1.req_op = 3'b000; bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
        test_reset();
        test_lw();
        test_subword_loads();
        test_sb();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        test_read_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
